register_file: RTL and testbench

- General-purpose register file for the ARM-style pipelined core.
- Two combinational read ports feed the ID stage operand fetch.
- One synchronous write port is driven by the WB stage.
- Write-through bypass: a value written in WB is visible to ID in the same cycle.

---
 rtl/core_pkg.sv | 10 +
 rtl/register_file.sv | 54 +++++
 tb/tb_register_file.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: the word and register-specifier widths used by the ID and WB stages.
package core_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports with write-through
// bypass from WB, one synchronous write port, reset loads Ri = i.
module register_file #(
  parameter int DATA_W   = core_pkg::DATA_W,
  parameter int ADDR_W   = core_pkg::ADDR_W,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic              rst,
  input  logic              clk,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] destWB,
  input  logic [DATA_W-1:0] valueWB
);

  import core_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              byp_en;

  // Reset wins over a same-edge write, so the pending WB value is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (WB_EN) begin
      regs[destWB] <= valueWB;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] src,
    input logic              bypass,
    input logic [ADDR_W-1:0] dst,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (bypass && (src == dst)) begin
      return wdata;
    end
    return stored;
  endfunction

  // No bypass while in reset: readers see the array, not the discarded write.
  assign byp_en = WB_EN && !rst;

  assign reg1 = read_port(src1, byp_en, destWB, valueWB, regs[src1]);
  assign reg2 = read_port(src2, byp_en, destWB, valueWB, regs[src2]);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: scoreboard queue of expected read values,
// one task per scenario.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  src1, src2;
  logic [31:0] reg1, reg2;
  logic        WB_EN;
  logic [3:0]  destWB;
  logic [31:0] valueWB;

  int checks;
  int errors;

  logic [31:0] m [16];
  logic [31:0] sbq [$];

  register_file dut (
    .rst(rst), .clk(clk), .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
    .WB_EN(WB_EN), .destWB(destWB), .valueWB(valueWB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value for one port given the current inputs and model contents.
  function automatic logic [31:0] exp_rd(input logic [3:0] idx);
    if (!rst && WB_EN && idx == destWB) return valueWB;
    return m[idx];
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] = 32'(i);
    end else if (WB_EN) begin
      m[destWB] = valueWB;
    end
  endtask

  task automatic write_reg(input logic [3:0] d, input logic [31:0] v);
    @(negedge clk);
    WB_EN = 1'b1; destWB = d; valueWB = v;
    step();
    @(negedge clk);
    WB_EN = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e1, e2;
    rst = 1'b1; WB_EN = 1'b0; destWB = '0; valueWB = '0; src1 = '0; src2 = '0;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      src1 = 4'(i); src2 = 4'(15 - i);
      sbq.push_back(32'(i));
      sbq.push_back(32'(15 - i));
      #1;
      e1 = sbq.pop_front(); e2 = sbq.pop_front();
      checks += 2;
      if (reg1 !== e1) begin errors++; $display("FAIL reset_reg1 src=%0d got %h want %h", i, reg1, e1); end
      if (reg2 !== e2) begin errors++; $display("FAIL reset_reg2 src=%0d got %h want %h", 15 - i, reg2, e2); end
    end
  endtask

  task automatic test_seq_writes();
    logic [31:0] e;
    write_reg(4'd0, 32'h1);
    write_reg(4'd1, 32'h2);
    write_reg(4'd2, 32'h4);
    src1 = 4'd1; src2 = 4'd2;
    sbq.push_back(32'h2); sbq.push_back(32'h4);
    #1;
    checks += 2;
    e = sbq.pop_front();
    if (reg1 !== e) begin errors++; $display("FAIL seq_r1 got %h want %h", reg1, e); end
    e = sbq.pop_front();
    if (reg2 !== e) begin errors++; $display("FAIL seq_r2 got %h want %h", reg2, e); end
    src1 = 4'd0;
    sbq.push_back(32'h1);
    #1;
    checks++;
    e = sbq.pop_front();
    if (reg1 !== e) begin errors++; $display("FAIL seq_r0 got %h want %h", reg1, e); end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    @(negedge clk);
    src1 = 4'd2; src2 = 4'd2;
    WB_EN = 1'b1; destWB = 4'd2; valueWB = 32'hDEADBEEF;
    sbq.push_back(32'hDEADBEEF); sbq.push_back(32'hDEADBEEF);
    #1;
    checks += 2;
    e = sbq.pop_front();
    if (reg1 !== e) begin errors++; $display("FAIL bypass_r1 got %h want %h", reg1, e); end
    e = sbq.pop_front();
    if (reg2 !== e) begin errors++; $display("FAIL bypass_r2 got %h want %h", reg2, e); end
    step();
    @(negedge clk);
    WB_EN = 1'b0;
    sbq.push_back(32'hDEADBEEF); sbq.push_back(32'hDEADBEEF);
    #1;
    checks += 2;
    e = sbq.pop_front();
    if (reg1 !== e) begin errors++; $display("FAIL persist_r1 got %h want %h", reg1, e); end
    e = sbq.pop_front();
    if (reg2 !== e) begin errors++; $display("FAIL persist_r2 got %h want %h", reg2, e); end
  endtask

  task automatic test_write_disabled();
    logic [31:0] e;
    @(negedge clk);
    WB_EN = 1'b0; destWB = 4'd5; valueWB = 32'hFFFFFFFF; src1 = 4'd5;
    for (int k = 0; k < 3; k++) begin
      sbq.push_back(32'h5);
      #1;
      checks++;
      e = sbq.pop_front();
      if (reg1 !== e) begin errors++; $display("FAIL wdis_r5 pass=%0d got %h want %h", k, reg1, e); end
      step();
      @(negedge clk);
    end
    sbq.push_back(32'h5);
    #1;
    checks++;
    e = sbq.pop_front();
    if (reg1 !== e) begin errors++; $display("FAIL wdis_final got %h want %h", reg1, e); end
  endtask

  task automatic test_reset_priority();
    logic [31:0] e;
    write_reg(4'd3, 32'h00000077);
    rst = 1'b1; WB_EN = 1'b1; destWB = 4'd3; valueWB = 32'hAAAA5555;
    src1 = 4'd3; src2 = 4'd2;
    sbq.push_back(32'h00000077);
    #1;
    checks++;
    e = sbq.pop_front();
    if (reg1 !== e) begin errors++; $display("FAIL rstpri_nobypass got %h want %h", reg1, e); end
    step();
    @(negedge clk);
    rst = 1'b0; WB_EN = 1'b0;
    sbq.push_back(32'h3); sbq.push_back(32'h2);
    #1;
    checks += 2;
    e = sbq.pop_front();
    if (reg1 !== e) begin errors++; $display("FAIL rstpri_r3 got %h want %h", reg1, e); end
    e = sbq.pop_front();
    if (reg2 !== e) begin errors++; $display("FAIL rstpri_r2 got %h want %h", reg2, e); end
  endtask

  task automatic test_boundary();
    logic [31:0] e1, e2;
    write_reg(4'd15, 32'h12345678);
    write_reg(4'd0, 32'h0);
    src1 = 4'd15; src2 = 4'd0;
    sbq.push_back(32'h12345678); sbq.push_back(32'h0);
    #1;
    checks += 2;
    e1 = sbq.pop_front(); e2 = sbq.pop_front();
    if (reg1 !== e1) begin errors++; $display("FAIL bound_r15 got %h want %h", reg1, e1); end
    if (reg2 !== e2) begin errors++; $display("FAIL bound_r0 got %h want %h", reg2, e2); end
    for (int i = 1; i < 15; i++) begin
      src1 = 4'(i); src2 = 4'(i);
      sbq.push_back(32'(i)); sbq.push_back(exp_rd(4'(i)));
      #1;
      checks += 2;
      e1 = sbq.pop_front(); e2 = sbq.pop_front();
      if (reg1 !== e1) begin errors++; $display("FAIL bound_other r%0d got %h want %h", i, reg1, e1); end
      if (reg2 !== reg1 || reg2 !== e2) begin errors++; $display("FAIL bound_same r%0d got %h want %h", i, reg2, e2); end
    end
  endtask

  // WB_EN held high writes every cycle; both ports read the model with bypass.
  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    logic [3:0]  dsts [6] = '{4'd4, 4'd5, 4'd4, 4'd9, 4'd9, 4'd5};
    @(negedge clk);
    src1 = 4'd4; src2 = 4'd5;
    for (int k = 0; k < 6; k++) begin
      WB_EN = 1'b1; destWB = dsts[k]; valueWB = $urandom;
      sbq.push_back(exp_rd(src1)); sbq.push_back(exp_rd(src2));
      #1;
      checks += 2;
      e1 = sbq.pop_front(); e2 = sbq.pop_front();
      if (reg1 !== e1) begin errors++; $display("FAIL b2b_r1 k=%0d got %h want %h", k, reg1, e1); end
      if (reg2 !== e2) begin errors++; $display("FAIL b2b_r2 k=%0d got %h want %h", k, reg2, e2); end
      step();
      @(negedge clk);
    end
    WB_EN = 1'b0;
    for (int i = 0; i < 16; i++) begin
      src1 = 4'(i); src2 = 4'(15 - i);
      sbq.push_back(m[i]); sbq.push_back(m[15 - i]);
      #1;
      checks += 2;
      e1 = sbq.pop_front(); e2 = sbq.pop_front();
      if (reg1 !== e1) begin errors++; $display("FAIL b2b_sweep1 r%0d got %h want %h", i, reg1, e1); end
      if (reg2 !== e2) begin errors++; $display("FAIL b2b_sweep2 r%0d got %h want %h", 15 - i, reg2, e2); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_seq_writes();
    test_bypass();
    test_write_disabled();
    test_reset_priority();
    test_boundary();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
